// File: rtl/gate_delay_meter.sv
// Propagation-delay meter: counts clock edges from a stimulus change to each
// channel's response toggle, then reports per-channel delays, spread and slowest.
module gate_delay_meter #(
  parameter int CHANNELS = 2,
  parameter int STIM_W   = 2,
  parameter int CNT_W    = 8,
  parameter int IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [STIM_W-1:0]         stim,
  input  logic [CHANNELS-1:0]       resp,
  output logic                      busy,
  output logic                      meas_valid,
  output logic [CHANNELS*CNT_W-1:0] delay,
  output logic [CHANNELS-1:0]       timeout,
  output logic [CNT_W-1:0]          spread,
  output logic [IDX_W-1:0]          slowest,
  output logic                      overrun
);

  localparam logic [CNT_W-1:0] MAX = '1;

  typedef enum logic [1:0] {IDLE, MEASURE, REPORT} state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic [STIM_W-1:0]           r_stim_q;
  logic [CHANNELS-1:0]         r_resp_q;
  logic [CNT_W-1:0]            r_cnt;
  logic [CHANNELS-1:0]         r_done;
  logic [CHANNELS*CNT_W-1:0]   r_delay;
  logic [CHANNELS-1:0]         r_timeout;
  logic [CNT_W-1:0]            r_spread;
  logic [IDX_W-1:0]            r_slowest;
  logic                        r_meas_valid;
  logic                        r_overrun;

  logic                        w_stim_evt;
  logic [CHANNELS-1:0]         w_resp_chg;
  logic [CHANNELS-1:0]         w_done_next;
  logic                        w_all_done;
  logic                        w_start;
  logic [CNT_W-1:0]            w_max;
  logic [CNT_W-1:0]            w_min;
  logic [CNT_W-1:0]            w_d;
  logic                        w_any;
  logic [IDX_W-1:0]            w_slow_idx;
  logic [CNT_W-1:0]            w_spread;
  logic [IDX_W-1:0]            w_slowest;

  assign w_stim_evt = (stim != r_stim_q);
  assign w_resp_chg = resp ^ r_resp_q;
  assign w_start    = (r_state == IDLE) && w_stim_evt && en;

  // Done bits as they will be after this edge; drives the REPORT transition.
  always_comb begin
    w_done_next = r_done;
    if (w_start) begin
      w_done_next = w_resp_chg;
    end else if (r_state == MEASURE && en) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!r_done[i] && (w_resp_chg[i] || r_cnt == MAX)) w_done_next[i] = 1'b1;
      end
    end
    w_all_done = &w_done_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = w_all_done ? REPORT : MEASURE;
      MEASURE: if (!en) w_next = IDLE;
               else if (w_all_done) w_next = REPORT;
      REPORT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Timed-out channels are excluded; ties keep the lowest index as slowest.
  always_comb begin
    w_max      = '0;
    w_min      = '1;
    w_d        = '0;
    w_any      = 1'b0;
    w_slow_idx = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!r_timeout[i]) begin
        w_d = r_delay[i*CNT_W +: CNT_W];
        if (!w_any || w_d > w_max) begin
          w_max      = w_d;
          w_slow_idx = IDX_W'(i);
        end
        if (!w_any || w_d < w_min) w_min = w_d;
        w_any = 1'b1;
      end
    end
    w_spread  = w_any ? (w_max - w_min) : '0;
    w_slowest = w_any ? w_slow_idx : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stim_q     <= '0;
      r_resp_q     <= '0;
      r_cnt        <= '0;
      r_done       <= '0;
      r_delay      <= '0;
      r_timeout    <= '0;
      r_spread     <= '0;
      r_slowest    <= '0;
      r_meas_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_stim_q     <= stim;
      r_resp_q     <= resp;
      r_meas_valid <= 1'b0;
      r_done       <= (w_next == IDLE) ? '0 : w_done_next;
      if (w_stim_evt && r_state != IDLE) r_overrun <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_cnt     <= CNT_W'(1);
            r_timeout <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
              if (w_resp_chg[i]) r_delay[i*CNT_W +: CNT_W] <= '0;
            end
          end
        end
        MEASURE: begin
          if (en) begin
            if (r_cnt != MAX) r_cnt <= r_cnt + 1'b1;
            for (int i = 0; i < CHANNELS; i++) begin
              if (!r_done[i]) begin
                if (w_resp_chg[i]) begin
                  r_delay[i*CNT_W +: CNT_W] <= r_cnt;
                end else if (r_cnt == MAX) begin
                  r_delay[i*CNT_W +: CNT_W] <= MAX;
                  r_timeout[i]              <= 1'b1;
                end
              end
            end
          end
        end
        REPORT: begin
          if (en) begin
            r_spread     <= w_spread;
            r_slowest    <= w_slowest;
            r_meas_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (r_state != IDLE);
  assign meas_valid = r_meas_valid;
  assign delay      = r_delay;
  assign timeout    = r_timeout;
  assign spread     = r_spread;
  assign slowest    = r_slowest;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_gate_delay_meter.sv
// Directed bench for gate_delay_meter (CHANNELS=2, CNT_W=8) with hand-computed
// expected delays, spread, slowest index and meas_valid timing.
module tb_gate_delay_meter;

  logic        clk;
  logic        rst;
  logic        en;
  logic [1:0]  stim;
  logic [1:0]  resp;
  logic        busy;
  logic        meas_valid;
  logic [15:0] delay;
  logic [1:0]  timeout;
  logic [7:0]  spread;
  logic [0:0]  slowest;
  logic        overrun;

  int checks   = 0;
  int failures = 0;
  int kValid;

  gate_delay_meter #(.CHANNELS(2), .STIM_W(2), .CNT_W(8), .IDX_W(1)) dut (
    .clk(clk), .rst(rst), .en(en), .stim(stim), .resp(resp),
    .busy(busy), .meas_valid(meas_valid), .delay(delay), .timeout(timeout),
    .spread(spread), .slowest(slowest), .overrun(overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edge S detects the stim change; channel c toggles before edge S+d (d<0: never).
  // Returns k such that meas_valid was first seen after edge S+k, or -1.
  task automatic run_meas(input logic [1:0] s, input int d0, input int d1,
                          input int ovK, output int k);
    stim = s;
    if (d0 == 0) resp[0] = ~resp[0];
    if (d1 == 0) resp[1] = ~resp[1];
    tick();
    k = -1;
    for (int e = 1; e <= 300; e++) begin
      if (d0 == e) resp[0] = ~resp[0];
      if (d1 == e) resp[1] = ~resp[1];
      if (ovK == e) stim = stim ^ 2'b01;
      tick();
      if (meas_valid) begin
        k = e;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; stim = 2'b00; resp = 2'b00;
    #3;
    checks++;
    if ({busy, meas_valid, delay, timeout, spread, slowest, overrun} !== 30'd0) begin
      failures++;
      $display("FAIL reset_outputs actual=%h expected=0",
               {busy, meas_valid, delay, timeout, spread, slowest, overrun});
    end
    @(negedge clk);
    rst = 1'b0;
    stim = 2'b01;
    tick();
    tick();
    en = 1'b1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL idle_no_en busy=%b expected=0", busy); end
  endtask

  task automatic test_basic();
    run_meas(2'b11, 8, 7, -1, kValid);
    checks++;
    if (kValid !== 9) begin failures++; $display("FAIL basic_valid_edge actual=%0d expected=9", kValid); end
    checks++;
    if (delay !== {8'd7, 8'd8}) begin failures++; $display("FAIL basic_delay actual=%h expected=0708", delay); end
    checks++;
    if (spread !== 8'd1 || slowest !== 1'b0) begin
      failures++; $display("FAIL basic_spread spread=%0d slowest=%0d expected=1/0", spread, slowest);
    end
    checks++;
    if (busy !== 1'b0 || timeout !== 2'b00) begin
      failures++; $display("FAIL basic_busy busy=%b timeout=%b expected=0/00", busy, timeout);
    end
    tick();
    checks++;
    if (meas_valid !== 1'b0) begin failures++; $display("FAIL basic_pulse_width meas_valid=%b expected=0", meas_valid); end
  endtask

  task automatic test_spread();
    run_meas(2'b10, 5, 8, -1, kValid);
    checks++;
    if (kValid !== 9 || delay !== {8'd8, 8'd5}) begin
      failures++; $display("FAIL spread1_delay k=%0d delay=%h expected=9/0805", kValid, delay);
    end
    checks++;
    if (spread !== 8'd3 || slowest !== 1'b1) begin
      failures++; $display("FAIL spread1_result spread=%0d slowest=%0d expected=3/1", spread, slowest);
    end
    tick();
    run_meas(2'b11, 7, 7, -1, kValid);
    checks++;
    if (kValid !== 8 || spread !== 8'd0 || slowest !== 1'b0) begin
      failures++; $display("FAIL spread_tie k=%0d spread=%0d slowest=%0d expected=8/0/0", kValid, spread, slowest);
    end
    tick();
  endtask

  task automatic test_timeout();
    run_meas(2'b01, 4, -1, -1, kValid);
    checks++;
    if (kValid !== 256) begin failures++; $display("FAIL timeout_valid_edge actual=%0d expected=256", kValid); end
    checks++;
    if (delay !== {8'd255, 8'd4} || timeout !== 2'b10) begin
      failures++; $display("FAIL timeout_delay delay=%h timeout=%b expected=ff04/10", delay, timeout);
    end
    checks++;
    if (spread !== 8'd0 || slowest !== 1'b0) begin
      failures++; $display("FAIL timeout_spread spread=%0d slowest=%0d expected=0/0", spread, slowest);
    end
    tick();
  endtask

  task automatic test_zero_delay();
    run_meas(2'b11, 0, 0, -1, kValid);
    checks++;
    if (kValid !== 1) begin failures++; $display("FAIL zero_valid_edge actual=%0d expected=1", kValid); end
    checks++;
    if (delay !== 16'h0000 || timeout !== 2'b00 || spread !== 8'd0) begin
      failures++; $display("FAIL zero_result delay=%h timeout=%b spread=%0d expected=0000/00/0", delay, timeout, spread);
    end
    tick();
  endtask

  task automatic test_overrun();
    checks++;
    if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_pre actual=%b expected=0", overrun); end
    run_meas(2'b10, 6, 4, 3, kValid);
    checks++;
    if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_set actual=%b expected=1", overrun); end
    checks++;
    if (kValid !== 7 || delay !== {8'd4, 8'd6} || spread !== 8'd2 || slowest !== 1'b0) begin
      failures++;
      $display("FAIL overrun_meas k=%0d delay=%h spread=%0d slowest=%0d expected=7/0406/2/0", kValid, delay, spread, slowest);
    end
    tick();
    tick();
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL overrun_sticky overrun=%b busy=%b expected=1/0", overrun, busy);
    end
  endtask

  task automatic test_en_abort();
    int seenValid;
    seenValid = 0;
    stim = 2'b00;
    tick();
    tick();
    tick();
    tick();
    en = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy_before actual=%b expected=1", busy); end
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL abort_idle actual=%b expected=0", busy); end
    for (int e = 0; e < 10; e++) begin
      tick();
      if (meas_valid) seenValid++;
    end
    checks++;
    if (seenValid !== 0) begin failures++; $display("FAIL abort_no_valid count=%0d expected=0", seenValid); end
    checks++;
    if (delay !== {8'd4, 8'd6} || spread !== 8'd2) begin
      failures++; $display("FAIL abort_hold delay=%h spread=%0d expected=0406/2", delay, spread);
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    stim = 2'b11;
    tick();
    tick();
    tick();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy actual=%b expected=1", busy); end
    #2;
    rst = 1'b1;
    en = 1'b0;
    #1;
    checks++;
    if ({busy, meas_valid, delay, timeout, spread, slowest, overrun} !== 30'd0) begin
      failures++;
      $display("FAIL rstmid_outputs actual=%h expected=0",
               {busy, meas_valid, delay, timeout, spread, slowest, overrun});
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_spread();
    test_timeout();
    test_zero_delay();
    test_overrun();
    test_en_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_delay_meter.md
# gate_delay_meter

Cycle-accurate propagation-delay meter for comparing gate implementations under test. It watches a stimulus bus and CHANNELS response lines, one per implementation. For each stimulus change it counts clock edges until every response toggles or times out, then reports the per-channel delays, the spread between fastest and slowest, and the slowest channel. It sits beside the gate models on the test harness and replaces manual waveform reading of delay differences.

## Interface
- CHANNELS, 2, number of response channels (≥1)
- STIM_W, 2, stimulus bus width
- CNT_W, 8, delay counter width; MAX = 2^CNT_W − 1
- IDX_W, max(1,$clog2(CHANNELS)), channel index width
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  arm enable; deassertion aborts a measurement
- stim  in  STIM_W  stimulus applied to the gates
- resp  in  CHANNELS  one response bit per channel
- busy  out  1  high in MEASURE and REPORT
- meas_valid  out  1  one-cycle pulse when results are final
- delay  out  CHANNELS*CNT_W  channel i delay at [i*CNT_W +: CNT_W]
- timeout  out  CHANNELS  channel i saw no response change by MAX
- spread  out  CNT_W  max − min delay over non-timed-out channels
- slowest  out  IDX_W  lowest index holding the max delay (non-timed-out)
- overrun  out  1  sticky: stim changed while not IDLE

## Operation
- Registers stim_q and resp_q sample stim and resp every edge in all states. A stimulus event is stim ≠ stim_q at an edge. Response change i is resp[i] ≠ resp_q[i].
- States IDLE, MEASURE, REPORT.
- IDLE: on stimulus event with en=1: go to MEASURE, cnt←1, clear done and timeout. Any channel with a response change at this same edge gets delay←0 and done.
- MEASURE, each edge, for every channel with done=0:
  - response change: delay←cnt, done←1.
  - else if cnt==MAX: delay←MAX, timeout←1, done←1.
  - A change at cnt==MAX records MAX with timeout=0.
- MEASURE, cnt←cnt+1 each edge. cnt never wraps, because all channels are done by cnt==MAX.
- When all done bits are set after the edge update, go to REPORT. This includes the start edge if all channels responded at delay 0.
- REPORT (one cycle): at the next edge, register spread and slowest, set meas_valid←1, go to IDLE.
- If every channel timed out, spread=0 and slowest=0.
- Spread is unsigned CNT_W arithmetic; max ≥ min, so it cannot wrap.
- Stimulus event in MEASURE or REPORT: ignored for measurement, overrun←1. overrun clears only on rst.
- en=0 in MEASURE or REPORT: go to IDLE at the next edge and clear done.
  - No meas_valid.
  - delay, timeout, spread and slowest keep their last written values.
- Outputs are held between measurements.

## Timing
- Reset (asynchronous): state IDLE; stim_q, resp_q, cnt, done cleared. All outputs 0: busy, meas_valid, delay, timeout, spread, slowest, overrun.
- Delay = number of clock edges from the stimulus-detect edge to the response-detect edge; 0 means the same edge.
- Last channel done at edge E:
  - REPORT during cycle E..E+1.
  - meas_valid high during cycle E+1..E+2 only.
  - busy falls after E+1.
  - Earliest next stimulus detection is edge E+2. A stimulus change detected at E+1 sets overrun and is lost.
- The delay field of channel i updates at its own detect edge. Consumers use the results only on meas_valid.
- Reset asserted mid-measurement takes effect immediately and clears everything.

## Test plan
- CHANNELS=2, CNT_W=8. stim 01→11 at edge S; resp0 toggles at S+8, resp1 at S+7 → delay0=8, delay1=7, spread=1, slowest=0, meas_valid at S+9.
- stim 11→10; resp0 at +5, resp1 at +8 → spread=3, slowest=1. Then 10→11 with both at +7 → spread=0, slowest=0.
- resp1 never toggles, resp0 at +4 → delay1=255, timeout=2'b10, spread=0, slowest=0, meas_valid after edge S+255+1.
- Both responses toggle on the stimulus-detect edge → delays 0/0, REPORT next cycle, meas_valid one cycle later.
- Second stim change at S+3 while measuring → overrun=1 and stays 1. Measurement continues unchanged; overrun clears only on rst.
- en dropped at S+3 → IDLE at S+4, no meas_valid. rst pulsed mid-MEASURE → all outputs 0 immediately.
